// File: rtl/dmem_bytelane_pkg.sv
// Shared definitions for the byte-lane data memory:
// funct3 size codes, control states and size helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    // Access width in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] n;
        case (funct3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane steering: byte enables, store shift,
// load extract/extend and the misalign/illegal flag.
module dmem_lane_unit
    import dmem_pkg::*;
#(
    parameter int  DATA_W    = 32,
    localparam int NUM_BYTES = DATA_W / 8,
    localparam int OFF_W     = $clog2(NUM_BYTES)
) (
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [OFF_W-1:0]     off,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DATA_W-1:0]    rword,
    output logic [NUM_BYTES-1:0] be,
    output logic [DATA_W-1:0]    wshift,
    output logic [DATA_W-1:0]    rdata,
    output logic                 err
);

    localparam logic [6:0] DW   = 7'(DATA_W);
    localparam bit         WIDE = (DATA_W == 64);

    logic [3:0]         nb;
    logic [6:0]         bits;
    logic [7:0]         off8;
    logic [7:0]         amask;
    logic [OFF_W+2:0]   bitoff;
    logic               illegal;
    logic               misal;
    logic [7:0]         be8;
    logic [DATA_W-1:0]  sh;
    logic [DATA_W-1:0]  lo;
    logic signed [DATA_W-1:0] sx;
    logic [6:0]         pad;
    logic               sgn;

    assign nb     = size_bytes(funct3);
    assign bits   = {nb, 3'b000};
    assign off8   = 8'(off);
    assign amask  = 8'(nb) - 8'd1;
    assign bitoff = {off, 3'b000};

    // 64-bit-only codes are illegal on a 32-bit word;
    // unsigned codes have no store meaning.
    assign illegal = (funct3 == 3'b111)
                   || (we && funct3[2])
                   || (!WIDE && (funct3 == F3_D))
                   || (!WIDE && (funct3 == F3_WU));

    // Natural alignment: offset bits below the size must be zero.
    assign misal = |(off8 & amask);
    assign err   = illegal | misal;

    // Lane mask for the access size before shifting to the offset.
    always_comb begin
        be8 = 8'hFF;
        unique case (1'b1)
            (nb == 4'd1): be8 = 8'h01;
            (nb == 4'd2): be8 = 8'h03;
            (nb == 4'd4): be8 = 8'h0F;
            default:      be8 = 8'hFF;
        endcase
    end

    assign be     = err ? '0 : (NUM_BYTES'(be8) << off);
    assign wshift = wdata << bitoff;

    // Bring the addressed bytes to bit 0, then trim and extend
    // by pushing them to the top and shifting back down.
    always_comb begin
        sh    = rword >> bitoff;
        pad   = (bits >= DW) ? 7'd0 : (DW - bits);
        sgn   = !funct3[2];
        lo    = sh << pad;
        sx    = $signed(lo) >>> pad;
        rdata = '0;
        if (!err && !we) begin
            if (sgn) begin
                rdata = sx;
            end else begin
                rdata = lo >> pad;
            end
        end
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Word-organised byte-addressed data RAM with a valid/ready
// request port, self-clearing init and registered response.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int OFF_W     = $clog2(NUM_BYTES);
    localparam int IDX_W     = ADDR_W - OFF_W;
    localparam int DEPTH     = 2 ** IDX_W;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0]    mem [DEPTH];
    state_t               state;
    state_t               state_nx;
    logic [IDX_W-1:0]     init_idx;
    logic [IDX_W-1:0]     idx;
    logic [OFF_W-1:0]     off;
    logic                 accept;
    logic [NUM_BYTES-1:0] be;
    logic [DATA_W-1:0]    wshift;
    logic [DATA_W-1:0]    rword;
    logic [DATA_W-1:0]    ld_data;
    logic                 lane_err;

    assign idx    = req_addr[ADDR_W-1:OFF_W];
    assign off    = req_addr[OFF_W-1:0];
    assign rword  = mem[idx];
    assign accept = req_valid && req_ready;

    dmem_lane_unit #(
        .DATA_W (DATA_W)
    ) u_lane (
        .we     (req_we),
        .funct3 (req_funct3),
        .off    (off),
        .wdata  (req_wdata),
        .rword  (rword),
        .be     (be),
        .wshift (wshift),
        .rdata  (ld_data),
        .err    (lane_err)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // Init runs once over every word, then the port opens.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state)
            S_INIT: begin
                if (init_idx == LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_nx = S_INIT;
        endcase
    end

    // Word pointer for the zeroing pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            init_idx <= '0;
        end else if (state == S_INIT) begin
            init_idx <= init_idx + 1'b1;
        end
    end

    // Array writes: zero fill during init, lane-masked stores after.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == S_INIT) begin
                mem[init_idx] <= '0;
            end else if (accept && req_we) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wshift[8*i +: 8];
                    end
                end
            end
        end
    end

    // One-cycle response; data and error hold between accepts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= lane_err;
                rsp_rdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane: one 32-bit and one
// 64-bit instance sharing clock and reset.
module tb_dmem_bytelane;

    logic        clk;
    logic        rst;

    logic        v32, we32;
    logic [10:0] a32;
    logic [31:0] wd32;
    logic [2:0]  f32;
    logic        rdy32, rv32, e32, done32;
    logic [31:0] rd32;

    logic        v64, we64;
    logic [10:0] a64;
    logic [63:0] wd64;
    logic [2:0]  f64;
    logic        rdy64, rv64, e64, done64;
    logic [63:0] rd64;

    int errors = 0;
    int checks = 0;

    dmem_bytelane #(.ADDR_W(11), .DATA_W(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v32),
        .req_ready  (rdy32),
        .req_we     (we32),
        .req_addr   (a32),
        .req_wdata  (wd32),
        .req_funct3 (f32),
        .rsp_valid  (rv32),
        .rsp_rdata  (rd32),
        .rsp_err    (e32),
        .init_done  (done32)
    );

    dmem_bytelane #(.ADDR_W(11), .DATA_W(64)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v64),
        .req_ready  (rdy64),
        .req_we     (we64),
        .req_addr   (a64),
        .req_wdata  (wd64),
        .req_funct3 (f64),
        .rsp_valid  (rv64),
        .rsp_rdata  (rd64),
        .rsp_err    (e64),
        .init_done  (done64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; response checked #1 after its accept edge.
    task automatic xfer(input bit wide, input logic we,
                        input logic [10:0] addr, input logic [63:0] wd,
                        input logic [2:0] f3, input logic [63:0] exp_d,
                        input logic exp_e, input string tag);
        @(negedge clk);
        if (wide) begin
            v64 = 1'b1; we64 = we; a64 = addr; wd64 = wd; f64 = f3;
        end else begin
            v32 = 1'b1; we32 = we; a32 = addr;
            wd32 = wd[31:0]; f32 = f3;
        end
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v64 = 1'b0;
        if (wide) begin
            chk({tag, ".valid"}, {63'd0, rv64}, 64'd1);
            chk({tag, ".rdata"}, rd64, exp_d);
            chk({tag, ".err"}, {63'd0, e64}, {63'd0, exp_e});
        end else begin
            chk({tag, ".valid"}, {63'd0, rv32}, 64'd1);
            chk({tag, ".rdata"}, {32'd0, rd32}, exp_d);
            chk({tag, ".err"}, {63'd0, e32}, {63'd0, exp_e});
        end
    endtask

    // Release reset and count edges until each init_done rises.
    task automatic wait_init(input string tag);
        int  n32;
        int  n64;
        bit  saw_rsp;
        n32 = 0;
        n64 = 0;
        saw_rsp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (rv32 || rv64) saw_rsp = 1'b1;
            if (done32 && n32 == 0) n32 = n;
            if (done64 && n64 == 0) n64 = n;
            if (n32 != 0 && n64 != 0) break;
        end
        v32 = 1'b0;
        chk({tag, ".cycles32"}, 64'(n32), 64'd512);
        chk({tag, ".cycles64"}, 64'(n64), 64'd256);
        chk({tag, ".ready32"}, {63'd0, rdy32}, 64'd1);
        chk({tag, ".ready64"}, {63'd0, rdy64}, 64'd1);
        chk({tag, ".no_rsp"}, {63'd0, saw_rsp}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        v32 = 1'b0; we32 = 1'b0; a32 = '0; wd32 = '0; f32 = '0;
        v64 = 1'b0; we64 = 1'b0; a64 = '0; wd64 = '0; f64 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready32", {63'd0, rdy32}, 64'd0);
        chk("rst.valid32", {63'd0, rv32}, 64'd0);
        chk("rst.rdata32", {32'd0, rd32}, 64'd0);
        chk("rst.err32", {63'd0, e32}, 64'd0);
        chk("rst.done32", {63'd0, done32}, 64'd0);
        chk("rst.done64", {63'd0, done64}, 64'd0);

        // A store held during init must be ignored.
        @(negedge clk);
        v32 = 1'b1; we32 = 1'b1; a32 = 11'h000;
        wd32 = 32'hFFFFFFFF; f32 = 3'b010;
        wait_init("init1");

        xfer(0, 0, 11'h000, 0, 3'b010, 64'h0, 0, "lw0");
        xfer(0, 0, 11'h7FC, 0, 3'b010, 64'h0, 0, "lw_top");

        xfer(0, 1, 11'h010, 64'h8000FF80, 3'b010, 64'h0, 0, "sw10");
        xfer(0, 0, 11'h010, 0, 3'b000, 64'hFFFFFF80, 0, "lb10");
        xfer(0, 0, 11'h010, 0, 3'b100, 64'h00000080, 0, "lbu10");
        xfer(0, 0, 11'h012, 0, 3'b001, 64'hFFFF8000, 0, "lh12");
        xfer(0, 0, 11'h012, 0, 3'b101, 64'h00008000, 0, "lhu12");
        xfer(0, 0, 11'h011, 0, 3'b000, 64'hFFFFFFFF, 0, "lb11");

        xfer(0, 1, 11'h020, 64'h11223344, 3'b010, 64'h0, 0, "sw20");
        xfer(0, 1, 11'h021, 64'h555555AB, 3'b000, 64'h0, 0, "sb21");
        xfer(0, 0, 11'h020, 0, 3'b010, 64'h1122AB44, 0, "raw20");

        xfer(0, 1, 11'h004, 64'hCAFEF00D, 3'b010, 64'h0, 0, "sw04");
        xfer(0, 0, 11'h004, 0, 3'b010, 64'hCAFEF00D, 0, "lw04");

        // Idle cycle: no pulse, data holds.
        @(posedge clk);
        #1;
        chk("idle.valid", {63'd0, rv32}, 64'd0);
        chk("idle.rdata", {32'd0, rd32}, 64'hCAFEF00D);

        xfer(0, 0, 11'h003, 0, 3'b001, 64'h0, 1, "lh03_mis");
        xfer(0, 1, 11'h006, 64'hDEADBEEF, 3'b010, 64'h0, 1, "sw06_mis");
        xfer(0, 0, 11'h008, 0, 3'b011, 64'h0, 1, "ld32_ill");
        xfer(0, 1, 11'h004, 64'h000000EE, 3'b100, 64'h0, 1, "sbu_ill");
        xfer(0, 0, 11'h004, 0, 3'b010, 64'hCAFEF00D, 0, "lw04_kept");
        xfer(0, 0, 11'h000, 0, 3'b010, 64'h0, 0, "lw00_kept");

        xfer(1, 1, 11'h040, 64'h0123456789ABCDEF, 3'b011,
             64'h0, 0, "sd40");
        xfer(1, 0, 11'h044, 0, 3'b110, 64'h0000000001234567, 0, "lwu44");
        xfer(1, 0, 11'h040, 0, 3'b010, 64'hFFFFFFFF89ABCDEF, 0, "lw40");
        xfer(1, 0, 11'h040, 0, 3'b011, 64'h0123456789ABCDEF, 0, "ld40");
        xfer(1, 0, 11'h047, 0, 3'b100, 64'h0000000000000001, 0, "lbu47");
        xfer(1, 0, 11'h044, 0, 3'b011, 64'h0, 1, "ld44_mis");
        xfer(1, 0, 11'h040, 0, 3'b111, 64'h0, 1, "f3_111");

        // Reset in the cycle after a load accept.
        xfer(0, 0, 11'h020, 0, 3'b010, 64'h1122AB44, 0, "lw20_pre");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.valid", {63'd0, rv32}, 64'd0);
        chk("mid.rdata", {32'd0, rd32}, 64'd0);
        chk("mid.ready", {63'd0, rdy32}, 64'd0);
        wait_init("init2");

        xfer(0, 0, 11'h020, 0, 3'b010, 64'h0, 0, "lw20_post");
        xfer(1, 0, 11'h040, 0, 3'b011, 64'h0, 0, "ld40_post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
Parametrised successor to the single-cycle data memory. Byte-addressed, word-organised data RAM with a valid/ready request port and a registered one-cycle read response. Supports per-byte-lane load/store sizing with RISC-V funct3 encoding and misalignment/illegal-op error reporting. Runs a self-clearing init sequence after reset. Sits between the datapath's ALU/address stage and the writeback mux.

Parameters:
ADDR_W, 11, byte-address width; memory holds 2**ADDR_W bytes.
DATA_W, 32, word width; legal values 32 or 64.
NUM_BYTES, DATA_W/8 (derived localparam), byte lanes per word.
OFF_W, log2(NUM_BYTES) (derived localparam), byte-offset bits.
DEPTH, 2**(ADDR_W-OFF_W) (derived localparam), words in the array.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset; synchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned (bits [7:0] for SB).
req_funct3  in  3  access size/sign: instr[14:12].
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  DATA_W  load result, sign/zero-extended; 0 for stores and errors.
rsp_err  out  1  request was misaligned or illegal; qualified by rsp_valid.
init_done  out  1  init sequence complete.

Behaviour:
- Reset: rst==0 at a rising edge forces S_INIT, init_idx=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. Any pending response is discarded.
- S_INIT: each cycle writes all-zero to word init_idx, then increments it. After the edge that writes word DEPTH-1, go to S_RUN with init_done=1 and req_ready=1. Init takes exactly DEPTH cycles after reset release. Requests presented during init are ignored (req_ready=0).
- S_RUN: req_ready=1 every cycle, so throughput is one request per cycle. A request is accepted when req_valid && req_ready.
- Accepted request produces rsp_valid=1 on the following cycle, for exactly one cycle. There is no response backpressure. With no accept, rsp_valid=0 and rsp_rdata and rsp_err hold their last values.
- funct3 decode:
  - 000 B (signed)
  - 001 H (signed)
  - 010 W (signed when DATA_W=64)
  - 011 D (DATA_W=64 only)
  - 100 BU
  - 101 HU
  - 110 WU (DATA_W=64 only)
  - Any other combination, and any store with funct3[2]=1, is illegal.
- Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0. Bytes are always aligned.
- Error case: misaligned or illegal requests cause no write and give rsp_err=1, rsp_rdata=0.
- Store: on the accept edge, write only the lanes selected by the byte-enable. For size s at offset o, lanes o..o+s-1 are enabled and get wdata[8s-1:0] shifted left by 8*o. Other lanes are unchanged. Response: rsp_rdata=0, rsp_err=0.
- Load: on the accept edge, register the word at addr[ADDR_W-1:OFF_W]. Shift it right by 8*offset, truncate to the access size, then sign- or zero-extend to DATA_W.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes. The write lands on the store's edge, before the load's read edge.
- Addressing: there is no out-of-range access and no wrap logic; address is confined to ADDR_W bits.
- Reset asserted mid-run: the array is re-zeroed by the next init pass.

Decomposition:
- dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU
  - state enum {S_INIT, S_RUN}
  - function size_bytes(funct3)
- Sub-module dmem_lane_unit (combinational, parametrised by DATA_W). It generates the byte-enable mask, the shifted store data, load extraction/extension, and the misalign/illegal flag. The top level holds the array, the FSM, the init counter and the response registers.

Test Plan:
- Reset then idle (DATA_W=32, ADDR_W=11): init_done rises and req_ready=1 exactly 512 cycles after rst goes high. LW from any address returns 0x00000000.
- SW 0x8000FF80 @0x10, then LB @0x10, LBU @0x10, LH @0x12, LHU @0x12, LB @0x11: rdata in order is 0xFFFFFF80, 0x00000080, 0xFFFF8000, 0x00008000, 0xFFFFFFFF.
- SB 0xAB @0x21 over word 0x11223344 @0x20, then LW @0x20 back-to-back: rdata 0x1122AB44, confirming lane isolation and read-after-write.
- Misalign/illegal: LH @0x03, SW @0x06, funct3=011 with DATA_W=32. Each gives rsp_err=1 and rsp_rdata=0. A later LW of the targeted words shows them unchanged.
- DATA_W=64: SD 0x0123456789ABCDEF @0x40, then LWU @0x44 returns 0x0000000001234567 and LW @0x40 returns 0xFFFFFFFF89ABCDEF.
- Assert rst for one cycle mid-stream, in the cycle after a load accept: no rsp_valid follows. A new init pass runs, and LW @0x20 afterwards returns 0.
